// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch port (if_*)
//   and the load/store port (d_*). The winning request is registered onto
//   the m_* port and held until m_ready, or until a bounded wait expires,
//   at which point the requester is acked with zero data and err pulses.
//   A halt request, sampled only while idle, parks the arbiter until reset.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   if_req/addr       fetch request (held until if_ack)
//   if_rdata/ack      fetched word, one-cycle completion pulse
//   d_req/we/be/addr/wdata   load/store request (held until d_ack)
//   d_rdata/ack       load data, one-cycle completion pulse
//   m_req/we/be/addr/wdata   registered memory request
//   m_rdata/ready     memory read data, access completes this cycle
//   hlt               core halt request
//   err               pulses with the ack of a timed-out access
//   busy, halted      status: access in flight / parked
//
// Configuration
//   ARB_RR_EN  defined: round-robin between the two sides (last_owner bit,
//              reset to fetch). Undefined: fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  input  logic                hlt,
  output logic                err,
  output logic                busy,
  output logic                halted
);
  localparam int              BE_W     = DATA_W / 8;
  localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [BE_W-1:0] BE_ALL   = '1;

  typedef enum logic [1:0] {S_IDLE, S_IF_WAIT, S_D_WAIT, S_HALTED} state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic              r_m_req, r_m_we;
  logic [BE_W-1:0]   r_m_be;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata, r_if_rdata, r_d_rdata;
  logic              r_if_ack, r_d_ack, r_err;

  logic w_arb, w_d_elig, w_if_elig, w_grant_d, w_grant_if;
  logic w_zero_st, w_timeout, w_done;

  // A side whose ack is high this cycle is not eligible, which inserts one
  // dead cycle between back-to-back transactions from the same side.
  assign w_arb     = (r_state == S_IDLE) & ~hlt;
  assign w_d_elig  = d_req & ~r_d_ack;
  assign w_if_elig = if_req & ~r_if_ack;
  assign w_zero_st = d_we & (d_be == '0);
  assign w_timeout = (r_cnt == CNT_LAST) & ~m_ready;
  assign w_done    = m_ready | w_timeout;

`ifdef ARB_RR_EN
  logic r_last_d;  // 1: data side was served most recently

  assign w_grant_d = w_arb & w_d_elig & (~w_if_elig | ~r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_last_d <= 1'b0;
    else if (w_grant_d)  r_last_d <= 1'b1;
    else if (w_grant_if) r_last_d <= 1'b0;
  end
`else
  assign w_grant_d = w_arb & w_d_elig;
`endif

  assign w_grant_if = w_arb & w_if_elig & ~w_grant_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (hlt)                          w_next = S_HALTED;
        else if (w_grant_d && !w_zero_st) w_next = S_D_WAIT;
        else if (w_grant_if)              w_next = S_IF_WAIT;
      end
      S_IF_WAIT, S_D_WAIT: if (w_done) w_next = S_IDLE;
      default: w_next = S_HALTED;
    endcase
  end

  // Status outputs
  always_comb begin
    busy   = (r_state == S_IF_WAIT) || (r_state == S_D_WAIT);
    halted = (r_state == S_HALTED);
  end

  // Memory port, read data, ack/err pulses and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_be     <= '0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_d) begin
            // A store with no lanes enabled completes without a memory access.
            if (w_zero_st) begin
              r_d_ack <= 1'b1;
            end else begin
              r_m_req   <= 1'b1;
              r_m_we    <= d_we;
              r_m_be    <= d_be;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
            end
          end else if (w_grant_if) begin
            r_m_req  <= 1'b1;
            r_m_we   <= 1'b0;
            r_m_be   <= BE_ALL;
            r_m_addr <= if_addr;
          end
        end
        S_IF_WAIT, S_D_WAIT: begin
          if (w_done) begin
            // Completion wins over timeout if ready arrives on the last cycle.
            r_m_req <= 1'b0;
            r_cnt   <= '0;
            r_err   <= ~m_ready;
            if (r_state == S_IF_WAIT) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= m_ready ? m_rdata : '0;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= m_ready ? m_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_be     = r_m_be;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_rdata = r_if_rdata;
  assign if_ack   = r_if_ack;
  assign d_rdata  = r_d_rdata;
  assign d_ack    = r_d_ack;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        hlt = 1'b0;
  logic        err, busy, halted;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .hlt(hlt), .err(err), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: m_ready rises in the (lat+1)-th consecutive m_req cycle;
  // lat < 0 means the memory never answers.
  int          lat = 0;
  logic [31:0] rdval = '0;
  initial begin
    int hi;
    hi = 0;
    forever begin
      @(posedge clk);
      #2;
      if (m_req) begin
        m_ready = (lat >= 0) && (hi == lat);
        m_rdata = m_ready ? rdval : 32'hBAD0_BAD0;
        hi++;
      end else begin
        m_ready = 1'b0;
        m_rdata = 32'hBAD0_BAD0;
        hi = 0;
      end
    end
  end

  // Transaction-level reference: who owns the memory, how many cycles the
  // request has been outstanding, and what each side should see.
  int          owner = 0;   // 0 none, 1 fetch, 2 data, 3 parked
  int          waited = 0;  // cycles m_req has been high for the current owner
  logic        e_mreq = 0, e_mwe = 0, e_ifack = 0, e_dack = 0, e_err = 0, e_dchk = 1;
  logic [3:0]  e_mbe = 0;
  logic [31:0] e_maddr = 0, e_mwdata = 0, e_ifr = 0, e_dr = 0;

  initial begin
    logic pi, pd;
    logic [31:0] v;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        owner = 0; waited = 0;
        e_mreq = 0; e_mwe = 0; e_mbe = 0; e_maddr = 0; e_mwdata = 0;
        e_ifr = 0; e_dr = 0; e_ifack = 0; e_dack = 0; e_err = 0; e_dchk = 1;
      end else begin
        pi = e_ifack; pd = e_dack;
        e_ifack = 0; e_dack = 0; e_err = 0;
        if (owner == 0) begin
          if (hlt) owner = 3;
          else if (d_req && !pd) begin
            if (d_we && d_be == 4'h0) begin
              e_dack = 1; e_dchk = 0;
            end else begin
              owner = 2; waited = 0; e_mreq = 1;
              e_mwe = d_we; e_mbe = d_be; e_maddr = d_addr; e_mwdata = d_wdata;
            end
          end else if (if_req && !pi) begin
            owner = 1; waited = 0; e_mreq = 1;
            e_mwe = 0; e_mbe = 4'hF; e_maddr = if_addr;
          end
        end else if (owner == 1 || owner == 2) begin
          waited++;
          if (m_ready || waited == TMO) begin
            v = m_ready ? m_rdata : 32'h0;
            e_err = !m_ready;
            if (owner == 1) begin e_ifr = v; e_ifack = 1; end
            else begin e_dr = v; e_dack = 1; e_dchk = 1; end
            e_mreq = 0; owner = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the reference
  initial begin
    forever begin
      @(negedge clk);
      chk("m_req", m_req, e_mreq);
      if (e_mreq) begin
        chk("m_we", m_we, e_mwe);
        chk("m_be", m_be, e_mbe);
        chk("m_addr", m_addr, e_maddr);
        if (e_mwe) chk("m_wdata", m_wdata, e_mwdata);
      end
      chk("if_ack", if_ack, e_ifack);
      chk("d_ack", d_ack, e_dack);
      chk("err", err, e_err);
      chk("busy", busy, (owner == 1 || owner == 2));
      chk("halted", halted, (owner == 3));
      if (e_ifack) chk("if_rdata", if_rdata, e_ifr);
      if (e_dack && e_dchk) chk("d_rdata", d_rdata, e_dr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_d, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(is_d ? d_ack : if_ack) && n < 40);
    chk(is_d ? "d_ack_arrives" : "if_ack_arrives", is_d ? d_ack : if_ack, 1'b1);
  endtask

  initial begin
    int n, hi;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_m_req", m_req, 0);   chk("rst_m_we", m_we, 0);
    chk("rst_m_be", m_be, 0);     chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0); chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0); chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);   chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);     chk("rst_halted", halted, 0);
    rst = 1'b0;
    step();

    // Fetch only, memory answers one cycle after m_req
    lat = 1; rdval = 32'h0050_0093;
    if_req = 1; if_addr = 32'h10;
    step();
    chk("f_m_req", m_req, 1); chk("f_m_addr", m_addr, 32'h10);
    chk("f_m_we", m_we, 0);   chk("f_m_be", m_be, 4'hF);
    wait_ack(0, n);
    if_req = 0;
    chk("f_latency", n + 1, 3);
    chk("f_rdata", if_rdata, 32'h0050_0093);
    chk("f_err", err, 0);
    step();

    // Simultaneous store + fetch, immediate memory: store first
    lat = 0; rdval = 32'h1357_9BDF;
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("s_m_we", m_we, 1); chk("s_m_addr", m_addr, 32'h100);
    chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
    step();
    chk("s_d_ack_first", d_ack, 1); chk("s_if_not_yet", if_ack, 0);
    d_req = 0;
    wait_ack(0, n);
    if_req = 0;
    chk("s_if_after", n, 2);
    step();

    // Back-to-back loads from the same side: one dead cycle between them
    rdval = 32'h1111_2222;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
    wait_ack(1, n);
    chk("b_min_latency", n, 2);
    chk("b_rdata1", d_rdata, 32'h1111_2222);
    step();
    chk("b_dead_cycle", m_req, 0);
    rdval = 32'h3333_4444;
    step();
    chk("b_regrant", m_req, 1);
    wait_ack(1, n);
    d_req = 0;
    chk("b_rdata2", d_rdata, 32'h3333_4444);
    step();

    // Timeout: memory never answers
    lat = -1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
    n = 0; hi = 0;
    do begin
      step(); n++;
      if (m_req) hi++;
    end while (!d_ack && n < 40);
    d_req = 0;
    chk("t_ack", d_ack, 1);
    chk("t_mreq_cycles", hi, TMO);
    chk("t_err", err, 1);
    chk("t_rdata", d_rdata, 0);
    chk("t_idle", busy, 0);
    step();

    // Zero-byte store: acked next cycle with no memory access
    lat = 0;
    d_req = 1; d_we = 1; d_be = 4'h0; d_addr = 32'h500; d_wdata = 32'h1;
    step();
    chk("z_ack", d_ack, 1); chk("z_no_mreq", m_req, 0);
    d_req = 0;
    step();
    chk("z_no_mreq2", m_req, 0);

    // Reset in the middle of a load
    lat = -1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400;
    step();
    chk("r_m_req_before", m_req, 1); chk("r_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_async_m_req", m_req, 0);
    chk("r_async_d_ack", d_ack, 0);
    chk("r_async_busy", busy, 0);
    d_req = 0;
    step();
    rst = 1'b0;
    lat = 0; rdval = 32'hCAFE_F00D;
    if_req = 1; if_addr = 32'h80;
    wait_ack(0, n);
    if_req = 0;
    chk("r_fresh_latency", n, 2);
    chk("r_fresh_rdata", if_rdata, 32'hCAFE_F00D);
    step();

    // Halt while a fetch is in flight
    lat = 2; rdval = 32'h0000_0073;
    if_req = 1; if_addr = 32'h40;
    step();
    chk("h_granted", m_req, 1);
    hlt = 1;
    wait_ack(0, n);
    if_req = 0;
    chk("h_ack_latency", n, 3);
    chk("h_rdata", if_rdata, 32'h0000_0073);
    step();
    chk("h_halted", halted, 1);
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h600;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("h_no_mreq", m_req, 0);
      chk("h_no_dack", d_ack, 0);
    end
    d_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
